sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 85 ++++++++
 1 files changed

// File: rtl/sram_controller.sv
// sram_controller: serves 32-bit word loads/stores from a 16-bit asynchronous SRAM
// as two half-word phases (LO then HI), each held for SRAM_WAIT cycles.
module sram_controller #(
    parameter int SRAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_en,
    input  logic        write_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_data_out,
    input  logic [15:0] sram_data_in,
    output logic        sram_data_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;
    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);

    state_t      state_q;
    logic [3:0]  wait_q;
    logic [16:0] idx_q;
    logic [31:0] wdata_q, rdata_q;
    logic        phase_end, rd, wr, hi, unused_addr;

    assign phase_end   = wait_q == LAST;
    assign unused_addr = ^{address[31:19], address[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            // the wait counter restarts on every phase entry
            wait_q <= (state_q inside {IDLE, DONE} || phase_end) ? '0 : wait_q + 4'd1;
            case (state_q)
                IDLE: begin
                    if (write_en) begin
                        idx_q   <= address[18:2];
                        wdata_q <= write_data;
                        state_q <= WR_LO;
                    end else if (read_en) begin
                        idx_q   <= address[18:2];
                        state_q <= RD_LO;
                    end
                end
                RD_LO: if (phase_end) begin
                    rdata_q[15:0] <= sram_data_in;
                    state_q       <= RD_HI;
                end
                RD_HI: if (phase_end) begin
                    rdata_q[31:16] <= sram_data_in;
                    state_q        <= DONE;
                end
                WR_LO: if (phase_end) state_q <= WR_HI;
                WR_HI: if (phase_end) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd            = state_q inside {RD_LO, RD_HI};
    assign wr            = state_q inside {WR_LO, WR_HI};
    assign hi            = state_q inside {RD_HI, WR_HI};
    assign read_data     = rdata_q;
    assign ready         = state_q == DONE || (state_q == IDLE && !(read_en || write_en));
    assign sram_addr     = (rd || wr) ? {idx_q, hi} : '0;
    assign sram_data_out = wr ? (hi ? wdata_q[31:16] : wdata_q[15:0]) : '0;
    assign sram_data_oe  = wr;
    assign sram_ce_n     = !(rd || wr);
    assign sram_oe_n     = !rd;
    assign sram_we_n     = !wr;
    assign sram_ub_n     = !(rd || wr);
    assign sram_lb_n     = !(rd || wr);
endmodule
